// File: rtl/fir_tb_pkg.sv
// fir_tb_pkg: shared constants, state encoding and LFSR step for the FIR stimulus generator
package fir_tb_pkg;
  localparam int NB = 11;
  localparam int NCOEF = 9;
  localparam logic [1:0] GAP_CONT  = 2'b00;
  localparam logic [1:0] GAP_FIXED = 2'b01;
  localparam logic [1:0] GAP_LFSR  = 2'b10;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} st_t;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/fir_bubble_lfsr.sv
// fir_bubble_lfsr: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) deciding valid bubbles
module fir_bubble_lfsr import fir_tb_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic step_i,
  output logic bit0_o
);
  logic [LFSR_W-1:0] lfsr_q;
  // reseed on reset or run start, otherwise advance once per step
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) lfsr_q <= SEED;
    else if (load_i) lfsr_q <= SEED;
    else if (step_i) lfsr_q <= lfsr_next(lfsr_q);
  assign bit0_o = lfsr_q[0];
endmodule

// File: rtl/fir_stim_gen.sv
// fir_stim_gen: replays a preloaded sample table into the FIR DIN/VIN interface with paced valids, then drains
module fir_stim_gen #(
  parameter int NB = fir_tb_pkg::NB,
  parameter int AW = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tab_we_i,
  input  logic [AW-1:0]        tab_addr_i,
  input  logic [NB-1:0]        tab_data_i,
  input  logic                 coef_we_i,
  input  logic [3:0]           coef_sel_i,
  input  logic [NB-1:0]        coef_data_i,
  input  logic                 start_i,
  input  logic [AW:0]          num_smp_i,
  input  logic [1:0]           gap_mode_i,
  input  logic [3:0]           gap_len_i,
  output logic signed [NB-1:0] dout_o,
  output logic                 vout_o,
  output logic signed [NB-1:0] h0_o,
  output logic signed [NB-1:0] h1_o,
  output logic signed [NB-1:0] h2_o,
  output logic signed [NB-1:0] h3_o,
  output logic signed [NB-1:0] h4_o,
  output logic signed [NB-1:0] h5_o,
  output logic signed [NB-1:0] h6_o,
  output logic signed [NB-1:0] h7_o,
  output logic signed [NB-1:0] h8_o,
  output logic                 busy_o,
  output logic                 end_sim_o
);
  import fir_tb_pkg::*;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  st_t state_q, state_d;
  logic [AW:0] idx_q, idx_d, num_q, num_d, num_sat;
  logic [3:0] gap_q, gap_d, glen_q, glen_d;
  logic [1:0] mode_q, mode_d;
  logic [DW-1:0] drn_q, drn_d;
  logic [NB-1:0] dout_q, dout_d;
  logic vout_q, vout_d, start_ok, emit, lfsr_bit;
  logic [NB-1:0] tab_q [2**AW];
  logic [NB-1:0] h_q [NCOEF];
  assign busy_o    = state_q == ST_STREAM || state_q == ST_DRAIN;
  assign end_sim_o = state_q == ST_DONE;
  assign start_ok  = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign num_sat   = num_smp_i > DEPTH ? DEPTH : num_smp_i;
  assign emit      = state_q == ST_STREAM &&
                     (mode_q == GAP_FIXED ? gap_q == 4'd0 : mode_q == GAP_LFSR ? lfsr_bit : 1'b1);
  fir_bubble_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(start_ok),
    .step_i(state_q == ST_STREAM),
    .bit0_o(lfsr_bit)
  );
  // sample table is host-loaded between runs and deliberately survives reset
  always_ff @(posedge clk_i)
    if (tab_we_i && !busy_o) tab_q[tab_addr_i] <= tab_data_i;
  // coefficients frozen while a run is in progress so the FIR sees stable taps
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < NCOEF; i++) h_q[i] <= '0;
    else if (coef_we_i && !busy_o && coef_sel_i < 4'(NCOEF)) h_q[coef_sel_i] <= coef_data_i;
  // next-state and datapath: start latches run config, stream emits paced samples, drain zeroes DIN
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    gap_d   = gap_q;
    glen_d  = glen_q;
    mode_d  = mode_q;
    drn_d   = drn_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    if (start_ok) begin
      num_d   = num_sat;
      mode_d  = gap_mode_i;
      glen_d  = gap_len_i;
      idx_d   = '0;
      gap_d   = '0;
      drn_d   = '0;
      state_d = num_sat == '0 ? ST_DRAIN : ST_STREAM;
    end else if (state_q == ST_STREAM) begin
      gap_d = emit ? glen_q : (gap_q != 4'd0 ? gap_q - 4'd1 : gap_q);
      if (emit) begin
        dout_d  = tab_q[idx_q[AW-1:0]];
        vout_d  = 1'b1;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q + 1'b1 == num_q ? ST_DRAIN : ST_STREAM;
      end
    end else if (state_q == ST_DRAIN) begin
      dout_d  = '0;
      drn_d   = drn_q + 1'b1;
      state_d = drn_q == DW'(DRAIN_CYCLES - 1) ? ST_DONE : ST_DRAIN;
    end
  end
  // control and output registers
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      glen_q  <= '0;
      mode_q  <= '0;
      drn_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      glen_q  <= glen_d;
      mode_q  <= mode_d;
      drn_q   <= drn_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  assign dout_o = dout_q;
  assign vout_o = vout_q;
  assign h0_o = h_q[0];
  assign h1_o = h_q[1];
  assign h2_o = h_q[2];
  assign h3_o = h_q[3];
  assign h4_o = h_q[4];
  assign h5_o = h_q[5];
  assign h6_o = h_q[6];
  assign h7_o = h_q[7];
  assign h8_o = h_q[8];
endmodule

// File: tb/tb_fir_stim_gen.sv
// tb_fir_stim_gen: directed checks of pacing modes, drain timing, write gating and reset
module tb_fir_stim_gen;
  logic clk = 1'b0, rst = 1'b1;
  logic tab_we = 1'b0, coef_we = 1'b0, start = 1'b0;
  logic [7:0] tab_addr = '0;
  logic [10:0] tab_data = '0, coef_data = '0;
  logic [3:0] coef_sel = '0, glen = '0;
  logic [8:0] num = '0;
  logic [1:0] mode = '0;
  logic [10:0] dout;
  logic [10:0] h [9];
  logic vout, busy, end_sim;
  int checks = 0, failures = 0;
  int npulse, cyc, mism;
  logic vh [0:511];
  logic [10:0] dh [0:511];
  logic [10:0] dq [$];

  fir_stim_gen dut (
    .clk_i(clk), .rst_i(rst),
    .tab_we_i(tab_we), .tab_addr_i(tab_addr), .tab_data_i(tab_data),
    .coef_we_i(coef_we), .coef_sel_i(coef_sel), .coef_data_i(coef_data),
    .start_i(start), .num_smp_i(num), .gap_mode_i(mode), .gap_len_i(glen),
    .dout_o(dout), .vout_o(vout),
    .h0_o(h[0]), .h1_o(h[1]), .h2_o(h[2]), .h3_o(h[3]), .h4_o(h[4]),
    .h5_o(h[5]), .h6_o(h[6]), .h7_o(h[7]), .h8_o(h[8]),
    .busy_o(busy), .end_sim_o(end_sim)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tab(input logic [7:0] a, input logic [10:0] d);
    tab_we = 1'b1; tab_addr = a; tab_data = d;
    tick();
    tab_we = 1'b0;
  endtask

  task automatic wr_coef(input logic [3:0] s, input logic [10:0] d);
    coef_we = 1'b1; coef_sel = s; coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic run(input logic [8:0] n, input logic [1:0] m, input logic [3:0] g);
    num = n; mode = m; glen = g; start = 1'b1;
    tick();
    start = 1'b0; tab_we = 1'b0; coef_we = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_end_sim_clr", end_sim, 0);
    npulse = 0; cyc = 0; dq.delete();
    while (!end_sim && cyc < 400) begin
      tick();
      cyc++;
      vh[cyc] = vout;
      dh[cyc] = dout;
      if (vout) begin
        npulse++;
        dq.push_back(dout);
      end
    end
    chk("run_end_sim", end_sim, 1);
    chk("run_idle_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] s;
    logic [12:0] t2_pat;
    int e, c;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_vout", vout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_end_sim", end_sim, 0);
    chk("rst_h0", h[0], 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) wr_tab(8'(i), 11'(i + 1));
    for (int i = 0; i < 9; i++) wr_coef(4'(i), 11'd1);
    for (int i = 0; i < 9; i++) chk($sformatf("coef_h%0d", i), h[i], 1);

    // T1: continuous
    run(9'd8, 2'b00, 4'd0);
    chk("t1_pulses", npulse, 8);
    mism = 0;
    for (int i = 1; i <= 8; i++) if (vh[i] !== 1'b1 || dh[i] !== 11'(i)) mism++;
    chk("t1_consecutive_dout", mism, 0);
    chk("t1_drain_dout", dh[9], 0);
    chk("t1_end_sim_cycle", cyc, 24);

    // T2: fixed gap of 3
    run(9'd4, 2'b01, 4'd3);
    t2_pat = 13'b1000100010001;
    mism = 0;
    for (int i = 1; i <= 13; i++) if (vh[i] !== t2_pat[13 - i]) mism++;
    chk("t2_pattern", mism, 0);
    chk("t2_gap_hold1", dh[3], 1);
    chk("t2_gap_hold3", dh[12], 3);
    chk("t2_last", dh[13], 4);
    chk("t2_end_sim_cycle", cyc, 29);

    // T3: LFSR bubbles, golden model steps once per stream cycle
    run(9'd32, 2'b10, 4'd0);
    s = 8'hA5; e = 0; c = 0; mism = 0;
    while (e < 32 && c < 400) begin
      c++;
      if (vh[c] !== s[0]) mism++;
      if (s[0]) e++;
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    chk("t3_pattern", mism, 0);
    chk("t3_pulses", npulse, 32);
    chk("t3_end_sim_cycle", cyc, c + 16);
    chk("t3_last_dout", dq.size() == 32 ? dq[31] : 11'h0, 32);

    // T4: empty run
    run(9'd0, 2'b00, 4'd0);
    chk("t4_pulses", npulse, 0);
    chk("t4_end_sim_cycle", cyc, 16);

    // saturation of oversize sample count
    run(9'h1FF, 2'b11, 4'd0);
    chk("sat_pulses", npulse, 256);
    chk("sat_end_sim_cycle", cyc, 272);

    // T5: writes while busy are ignored, accepted in DONE
    num = 9'd8; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    coef_we = 1'b1; coef_sel = 4'd3; coef_data = 11'h7FF;
    tab_we = 1'b1; tab_addr = 8'd1; tab_data = 11'd99;
    tick();
    coef_we = 1'b0; tab_we = 1'b0;
    chk("t5_h3_locked", h[3], 1);
    c = 0;
    while (!end_sim && c < 100) begin tick(); c++; end
    chk("t5_done", end_sim, 1);
    wr_coef(4'd3, 11'h7FF);
    chk("t5_h3_written", h[3], 11'h7FF);
    tab_we = 1'b1; tab_addr = 8'd0; tab_data = 11'd50;
    run(9'd3, 2'b00, 4'd0);
    chk("t5_same_cycle_write", dq.size() > 0 ? dq[0] : 11'h0, 50);
    chk("t5_busy_write_ignored", dq.size() > 1 ? dq[1] : 11'h0, 2);

    // T6: async reset mid-stream
    num = 9'd8; mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t6_streaming", vout, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_vout", vout, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_h3", h[3], 0);
    tick();
    rst = 1'b0;
    tick();
    run(9'd3, 2'b00, 4'd0);
    chk("t6_replay0", dq.size() > 0 ? dq[0] : 11'h0, 50);
    chk("t6_replay2", dq.size() > 2 ? dq[2] : 11'h0, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
